// File: rtl/lif_scheduler_if.sv
// Bus between the LIF scheduler and its pin wrapper. It carries the per-neuron
// current fetch, the spike events and the step status.
interface lif_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8,
  parameter int IDX_W     = 2
);
  logic [IDX_W-1:0]     cur_idx;
  logic [W-1:0]         cur_in;
  logic                 busy;
  logic                 spike_valid;
  logic [IDX_W-1:0]     spike_id;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 step_done;

  modport master (
    output cur_idx,
    input  cur_in,
    output busy,
    output spike_valid,
    output spike_id,
    output spike_vec,
    output step_done
  );

  modport slave (
    input  cur_idx,
    output cur_in,
    input  busy,
    input  spike_valid,
    input  spike_id,
    input  spike_vec,
    input  step_done
  );
endinterface

// File: rtl/lif_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire scheduler. Each tick sweeps every
// virtual neuron once, one neuron per enabled cycle, and emits spike events.
module lif_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int W         = 8,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             tick,
  input  logic [1:0]       beta,
  input  logic [W-1:0]     threshold,
  output logic             overrun,
  input  logic [IDX_W-1:0] mon_sel,
  output logic [W-1:0]     mon_state,
  lif_scheduler_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [W-1:0]         mem [N_NEURONS];
  logic [N_NEURONS-1:0] pending;

  logic [W-1:0]         v;
  logic [W-1:0]         leak;
  logic [W:0]           nxt;
  logic [W-1:0]         nxt_sat;
  logic                 fire;
  logic [N_NEURONS-1:0] fire_vec;

  // v - leak never underflows, so one guard bit is enough for the add.
  always_comb begin
    v        = mem[idx];
    leak     = (beta == 2'd0) ? '0 : (v >> beta);
    nxt      = {1'b0, v} - {1'b0, leak} + {1'b0, bus.cur_in};
    nxt_sat  = nxt[W] ? '1 : nxt[W-1:0];
    fire     = (nxt_sat >= threshold);
    fire_vec = '0;
    fire_vec[idx] = fire;
  end

  assign bus.cur_idx = (state == RUN) ? idx : '0;
  assign bus.busy    = (state != IDLE);
  assign mon_state   = mem[mon_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      pending         <= '0;
      overrun         <= 1'b0;
      bus.spike_valid <= 1'b0;
      bus.spike_id    <= '0;
      bus.spike_vec   <= '0;
      bus.step_done   <= 1'b0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      bus.spike_valid <= 1'b0;
      bus.step_done   <= 1'b0;
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick && ena) begin
            state   <= RUN;
            idx     <= '0;
            pending <= '0;
          end
        end
        RUN: begin
          if (ena) begin
            mem[idx]        <= fire ? (nxt_sat - threshold) : nxt_sat;
            bus.spike_valid <= fire;
            if (fire) begin
              bus.spike_id <= idx;
            end
            pending <= pending | fire_vec;
            // Last neuron's spike is folded in directly; pending is not yet updated.
            if (idx == IDX_W'(N_NEURONS - 1)) begin
              state         <= DONE;
              bus.spike_vec <= pending | fire_vec;
              bus.step_done <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: a table of single-configuration runs plus
// hand-written sequences for stalls, overrun and mid-sweep reset.
module tb_lif_scheduler;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          tick = 1'b0;
  logic [1:0]    beta = '0;
  logic [W-1:0]  threshold = '0;
  logic          overrun;
  logic [IW-1:0] mon_sel = '0;
  logic [W-1:0]  mon_state;
  logic [W-1:0]  cur_tab [N];

  lif_scheduler_if #(.N_NEURONS(N), .W(W), .IDX_W(IW)) bus ();

  assign bus.cur_in = cur_tab[bus.cur_idx];

  lif_scheduler #(.N_NEURONS(N), .W(W), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .tick      (tick),
    .beta      (beta),
    .threshold (threshold),
    .overrun   (overrun),
    .mon_sel   (mon_sel),
    .mon_state (mon_state),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      beta;
    logic [7:0]      thr;
    logic [3:0][7:0] cur;
    int              steps;
    logic [3:0][7:0] mem;
    logic [3:0]      vec;
  } vec_t;

  vec_t tab [5];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [1:0] b, input logic [7:0] thr,
                              input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic [7:0] c3,
                              input int steps,
                              input logic [7:0] m0, input logic [7:0] m1,
                              input logic [7:0] m2, input logic [7:0] m3,
                              input logic [3:0] vec);
    vec_t r;
    r.beta = b;  r.thr = thr;
    r.cur[0] = c0; r.cur[1] = c1; r.cur[2] = c2; r.cur[3] = c3;
    r.steps = steps;
    r.mem[0] = m0; r.mem[1] = m1; r.mem[2] = m2; r.mem[3] = m3;
    r.vec = vec;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_mem(input string tag, input logic [3:0][7:0] exp);
    for (int i = 0; i < N; i++) begin
      mon_sel = IW'(i);
      #1;
      chk($sformatf("%s mem%0d", tag, i), int'(mon_state), int'(exp[i]));
    end
  endtask

  task automatic do_reset;
    tick  = 1'b0;
    ena   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_cfg(input vec_t c);
    beta      = c.beta;
    threshold = c.thr;
    for (int i = 0; i < N; i++) cur_tab[i] = c.cur[i];
  endtask

  task automatic wait_done(inout int cyc);
    while (!bus.step_done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Issues one tick and follows the sweep; latency counts negedges after the tick edge.
  task automatic run_step(output int latency, output int mask, output int in_order,
                          output int vec);
    int last;
    int cyc;
    mask = 0; in_order = 1; last = -1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc  = 1;
    forever begin
      if (bus.spike_valid) begin
        if (int'(bus.spike_id) <= last) in_order = 0;
        last = int'(bus.spike_id);
        mask = mask | (1 << bus.spike_id);
      end
      if (bus.step_done || cyc >= 50) break;
      @(negedge clk);
      cyc++;
    end
    latency = cyc;
    vec     = int'(bus.spike_vec);
    @(negedge clk);
  endtask

  initial begin
    int lat, mask, ord, vec, cyc, cnt;
    logic [3:0][7:0] zero_mem;
    logic [3:0][7:0] exp_mem;
    zero_mem = '0;
    for (int i = 0; i < N; i++) cur_tab[i] = '0;

    tab[0] = mk(2'd1, 8'd100, 8'd60, 8'd60, 8'd60, 8'd60, 3, 8'd5, 8'd5, 8'd5, 8'd5, 4'b1111);
    tab[1] = mk(2'd0, 8'd255, 8'd200, 8'd200, 8'd200, 8'd200, 2, 8'd0, 8'd0, 8'd0, 8'd0, 4'b1111);
    tab[2] = mk(2'd0, 8'd200, 8'd100, 8'd250, 8'd0, 8'd199, 1, 8'd100, 8'd50, 8'd0, 8'd199, 4'b0010);
    tab[3] = mk(2'd2, 8'd0, 8'd10, 8'd0, 8'd255, 8'd1, 2, 8'd18, 8'd0, 8'd255, 8'd2, 4'b1111);
    tab[4] = mk(2'd3, 8'd50, 8'd30, 8'd5, 8'd49, 8'd50, 2, 8'd7, 8'd10, 8'd42, 8'd0, 4'b1101);

    // Reset and idle
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle busy", int'(bus.busy), 0);
    chk("idle spike_valid", int'(bus.spike_valid), 0);
    chk("idle spike_id", int'(bus.spike_id), 0);
    chk("idle step_done", int'(bus.step_done), 0);
    chk("idle spike_vec", int'(bus.spike_vec), 0);
    chk("idle overrun", int'(overrun), 0);
    chk("idle cur_idx", int'(bus.cur_idx), 0);
    check_mem("idle", zero_mem);

    // Table-driven runs, each from reset
    for (int t = 0; t < 5; t++) begin
      do_reset;
      load_cfg(tab[t]);
      ena = 1'b1;
      for (int s = 0; s < tab[t].steps; s++) begin
        run_step(lat, mask, ord, vec);
        chk($sformatf("v%0d step%0d latency", t, s), lat, 5);
      end
      chk($sformatf("v%0d spike_vec", t), vec, int'(tab[t].vec));
      chk($sformatf("v%0d spike events", t), mask, int'(tab[t].vec));
      chk($sformatf("v%0d spike order", t), ord, 1);
      chk($sformatf("v%0d spike_vec held", t), int'(bus.spike_vec), int'(tab[t].vec));
      check_mem($sformatf("v%0d", t), tab[t].mem);
    end

    // ena low for 3 cycles at idx 2
    do_reset;
    load_cfg(tab[4]);
    ena  = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc  = 1;
    repeat (2) begin @(negedge clk); cyc++; end
    chk("stall cur_idx before", int'(bus.cur_idx), 2);
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cyc++;
      chk($sformatf("stall cur_idx hold%0d", k), int'(bus.cur_idx), 2);
      chk($sformatf("stall spike_valid%0d", k), int'(bus.spike_valid), 0);
    end
    ena = 1'b1;
    wait_done(cyc);
    chk("stall latency", cyc, 8);
    @(negedge clk);
    exp_mem[0] = 8'd30; exp_mem[1] = 8'd5; exp_mem[2] = 8'd49; exp_mem[3] = 8'd0;
    check_mem("stall step1", exp_mem);
    run_step(lat, mask, ord, vec);
    chk("stall step2 latency", lat, 5);
    chk("stall step2 spike_vec", vec, int'(tab[4].vec));
    check_mem("stall step2", tab[4].mem);

    // tick while busy
    do_reset;
    load_cfg(tab[0]);
    ena = 1'b1;
    chk("overrun after reset", int'(overrun), 0);
    tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tick = 1'b0;
    cyc  = 2;
    wait_done(cyc);
    chk("overrun step latency", cyc, 5);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy) cnt++;
    end
    chk("overrun no second step", cnt, 0);
    chk("overrun sticky", int'(overrun), 1);
    exp_mem[0] = 8'd60; exp_mem[1] = 8'd60; exp_mem[2] = 8'd60; exp_mem[3] = 8'd60;
    check_mem("overrun", exp_mem);
    do_reset;
    chk("overrun cleared by reset", int'(overrun), 0);

    // reset mid-sweep
    do_reset;
    load_cfg(tab[2]);
    ena = 1'b1;
    run_step(lat, mask, ord, vec);
    chk("midrst pre spike_vec", vec, 2);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    chk("midrst cur_idx", int'(bus.cur_idx), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", int'(bus.busy), 0);
    chk("midrst spike_vec", int'(bus.spike_vec), 0);
    check_mem("midrst", zero_mem);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.step_done) cnt++;
    end
    chk("midrst no step_done", cnt, 0);
    run_step(lat, mask, ord, vec);
    chk("midrst restart latency", lat, 5);
    chk("midrst restart spike_vec", vec, int'(tab[2].vec));
    check_mem("midrst restart", tab[2].mem);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
